// File: rtl/bus_target_pkg.sv
// bus_target_pkg: I/O map, STATUS layout and decode constants for bus_target
package bus_target_pkg;

    localparam logic [3:0] IO_TXDATA = 4'h0;
    localparam logic [3:0] IO_STATUS = 4'h1;
    localparam logic [3:0] IO_RELOAD = 4'h2;
    localparam logic [3:0] IO_COUNT  = 4'h3;

    localparam int ST_EMPTY = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_OVF   = 2;
    localparam int ST_TEXP  = 3;

    localparam int IO_SEL_BIT = 15;

    function automatic logic [15:0] status_word(input logic empty, input logic full,
                                                input logic ovf, input logic texp);
        logic [15:0] s;
        s = '0;
        s[ST_EMPTY] = empty;
        s[ST_FULL]  = full;
        s[ST_OVF]   = ovf;
        s[ST_TEXP]  = texp;
        return s;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word fall-through FIFO; pointers carry a wrap bit so full and empty differ
module sync_fifo #(
    parameter int W = 16,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          RES,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty
);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp, rp;
    logic         do_push, do_pop;

    assign level   = wp - rp;
    assign empty   = wp == rp;
    assign full    = level == (AW+1)'(DEPTH);
    assign do_pop  = pop && !empty;
    // a pop frees the slot in the same edge, so a full FIFO still takes the push
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rp[AW-1:0]];

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            wp <= '0;
            rp <= '0;
        end else begin
            wp <= wp + (AW+1)'(do_push);
            rp <= rp + (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) mem[wp[AW-1:0]] <= din;
    end

endmodule

// File: rtl/bus_target.sv
// bus_target: data-bus responder with word RAM, TX FIFO stream and reloadable timer
module bus_target
    import bus_target_pkg::*;
#(
    parameter int RAM_AW = 10,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic        RD,
    input  logic        WR,
    input  logic [15:0] ADDR,
    inout  wire  [15:0] DATA,
    output logic        OUT_VALID,
    output logic [15:0] OUT_DATA,
    input  logic        OUT_READY,
    output logic        IRQ
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic [15:0]   ram [2**RAM_AW];
    logic [15:0]   reload, count, count_next, rdata;
    logic [LW-1:0] level;
    logic          full, empty, ovf, texp;
    logic          io;
    logic [3:0]    off;
    logic          wr_ram, wr_tx, wr_st, wr_rl, pop, ovf_set, texp_set;
    logic          unused_addr;

    assign io          = ADDR[IO_SEL_BIT];
    assign off         = ADDR[3:0];
    assign unused_addr = ^ADDR[14:4];
    assign wr_ram      = WR && !io;
    assign wr_tx       = WR && io && off == IO_TXDATA;
    assign wr_st       = WR && io && off == IO_STATUS;
    assign wr_rl       = WR && io && off == IO_RELOAD;
    assign pop         = OUT_VALID && OUT_READY;
    assign ovf_set     = wr_tx && full && !pop;
    // expiry belongs to the decrement path, which a RELOAD write replaces
    assign texp_set    = !wr_rl && reload != '0 && count == 16'd1;

    sync_fifo #(.W(16), .DEPTH(FIFO_DEPTH)) u_fifo (
        .CLK   (CLK),
        .RES   (RES),
        .push  (wr_tx),
        .din   (DATA),
        .pop   (pop),
        .dout  (OUT_DATA),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    assign OUT_VALID = !empty;
    assign IRQ       = texp;

    always_ff @(posedge CLK) begin
        if (wr_ram) ram[ADDR[RAM_AW-1:0]] <= DATA;
    end

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            ovf  <= 1'b0;
            texp <= 1'b0;
        end else begin
            ovf  <= ovf_set  || (ovf  && !(wr_st && DATA[ST_OVF]));
            texp <= texp_set || (texp && !(wr_st && DATA[ST_TEXP]));
        end
    end

    always_comb begin
        count_next = wr_rl ? DATA :
                     reload == '0 ? count :
                     count <= 16'd1 ? reload :
                     count - 16'd1;
    end

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            reload <= '0;
            count  <= '0;
        end else begin
            if (wr_rl) reload <= DATA;
            count <= count_next;
        end
    end

    always_comb begin
        rdata = !io ? ram[ADDR[RAM_AW-1:0]] :
                off == IO_TXDATA ? 16'(level) :
                off == IO_STATUS ? status_word(empty, full, ovf, texp) :
                off == IO_RELOAD ? reload :
                off == IO_COUNT  ? count :
                '0;
    end

    assign DATA = (RD && !WR) ? rdata : 'z;

endmodule

// File: tb/tb_bus_target.sv
// tb_bus_target: scoreboard bench; bus reads and stream words are checked by separate monitors
module tb_bus_target;

    logic        CLK = 1'b0;
    logic        RES = 1'b1;
    logic        RD = 1'b0;
    logic        WR = 1'b0;
    logic [15:0] ADDR = '0;
    logic        OUT_READY = 1'b0;
    logic        OUT_VALID, IRQ;
    logic [15:0] OUT_DATA;
    wire  [15:0] DATA;
    logic [15:0] drv = '0;
    logic        drv_en = 1'b0;

    int tests = 0;
    int fails = 0;

    typedef struct {logic [15:0] a; logic [15:0] d;} rd_t;
    rd_t         rd_q [$];
    logic [15:0] out_q [$];

    assign DATA = drv_en ? drv : 'z;

    bus_target #(.RAM_AW(10), .FIFO_DEPTH(8)) dut (
        .CLK(CLK), .RES(RES), .RD(RD), .WR(WR), .ADDR(ADDR), .DATA(DATA),
        .OUT_VALID(OUT_VALID), .OUT_DATA(OUT_DATA), .OUT_READY(OUT_READY), .IRQ(IRQ)
    );

    always #10 CLK = ~CLK;

    task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (!RES && RD && !WR) begin
            if (rd_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rd_unexpected: got read at %h expected none", ADDR);
            end else begin
                rd_t e;
                e = rd_q.pop_front();
                chk($sformatf("rd@%h", e.a), DATA, e.d);
            end
        end
    end

    always @(negedge CLK) begin
        if (!RES && OUT_VALID && OUT_READY) begin
            if (out_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL out_unexpected: got %h expected none", OUT_DATA);
            end else begin
                chk("out_data", OUT_DATA, out_q.pop_front());
            end
        end
    end

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        WR = 1'b1; ADDR = a; drv = d; drv_en = 1'b1;
        @(posedge CLK); #1;
        WR = 1'b0; drv_en = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, input logic [15:0] e);
        rd_t t;
        t.a = a; t.d = e;
        rd_q.push_back(t);
        RD = 1'b1; ADDR = a;
        @(posedge CLK); #1;
        RD = 1'b0;
    endtask

    task automatic push(input logic [15:0] d, input bit expect_out);
        if (expect_out) out_q.push_back(d);
        wr(16'h8000, d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_out_valid", 16'(OUT_VALID), 16'h0);
        chk("rst_out_data", OUT_DATA, 16'h0);
        chk("rst_irq", 16'(IRQ), 16'h0);
        RES = 1'b0;
        rd(16'h8000, 16'h0000);
        rd(16'h8001, 16'h0001);
        rd(16'h8002, 16'h0000);
        rd(16'h8003, 16'h0000);

        wr(16'h0005, 16'h1234);
        rd(16'h0005, 16'h1234);
        rd(16'h0405, 16'h1234);
        wr(16'h8003, 16'h5555);
        rd(16'h8003, 16'h0000);
        rd(16'h8007, 16'h0000);
        rd(16'hFFF1, 16'h0001);

        for (int i = 0; i < 8; i++) push(16'h00A0 + 16'(i), 1'b1);
        push(16'h00FF, 1'b0);
        rd(16'h8000, 16'h0008);
        rd(16'h8001, 16'h0006);
        chk("full_head", OUT_DATA, 16'h00A0);
        OUT_READY = 1'b1;
        repeat (8) @(posedge CLK);
        #1;
        OUT_READY = 1'b0;
        chk("drain_a_left", 16'(out_q.size()), 16'h0);
        rd(16'h8000, 16'h0000);
        rd(16'h8001, 16'h0005);
        wr(16'h8001, 16'h0004);
        rd(16'h8001, 16'h0001);

        for (int i = 0; i < 8; i++) push(16'h00B0 + 16'(i), 1'b1);
        out_q.push_back(16'h0055);
        OUT_READY = 1'b1;
        wr(16'h8000, 16'h0055);
        OUT_READY = 1'b0;
        rd(16'h8000, 16'h0008);
        rd(16'h8001, 16'h0002);
        OUT_READY = 1'b1;
        repeat (8) @(posedge CLK);
        #1;
        OUT_READY = 1'b0;
        chk("drain_b_left", 16'(out_q.size()), 16'h0);
        rd(16'h8001, 16'h0001);

        wr(16'h8002, 16'h0003);
        rd(16'h8003, 16'h0003);
        rd(16'h8003, 16'h0002);
        rd(16'h8003, 16'h0001);
        rd(16'h8003, 16'h0003);
        rd(16'h8001, 16'h0009);
        chk("irq_set", 16'(IRQ), 16'h1);
        wr(16'h8001, 16'h0008);
        chk("irq_clear_vs_expiry", 16'(IRQ), 16'h1);
        rd(16'h8001, 16'h0009);
        wr(16'h8001, 16'h0008);
        chk("irq_cleared", 16'(IRQ), 16'h0);
        rd(16'h8001, 16'h0001);

        for (int i = 0; i < 4; i++) push(16'h00C0 + 16'(i), 1'b0);
        wr(16'h8002, 16'h0100);
        chk("pre_rst_valid", 16'(OUT_VALID), 16'h1);
        #2 RES = 1'b1;
        #1 chk("async_out_valid", 16'(OUT_VALID), 16'h0);
        chk("async_out_data", OUT_DATA, 16'h0);
        RD = 1'b1; ADDR = 16'h8003;
        #1 chk("async_count", DATA, 16'h0000);
        RD = 1'b0;
        @(posedge CLK); #1;
        RES = 1'b0;
        rd(16'h8000, 16'h0000);
        rd(16'h8003, 16'h0000);
        rd(16'h8002, 16'h0000);

        wr(16'h8002, 16'h00F0);
        RD = 1'b1; WR = 1'b1; ADDR = 16'h8002; drv = 16'h0007; drv_en = 1'b1;
        @(negedge CLK);
        chk("rdwr_bus", DATA, 16'h0007);
        @(posedge CLK); #1;
        RD = 1'b0; WR = 1'b0; drv_en = 1'b0;
        rd(16'h8002, 16'h0007);
        rd(16'h8003, 16'h0006);

        @(posedge CLK); #1;
        chk("rd_q_left", 16'(rd_q.size()), 16'h0);
        chk("out_q_left", 16'(out_q.size()), 16'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bus_target.md
# bus_target

Data-side bus responder for the 16-bit core: it answers the core's RD/WR/ADDR/DATA data bus, serving LOD and STO instructions. It contains a word RAM, a memory-mapped transmit FIFO that drains to a valid/ready output stream, and a reloadable down-counter timer with a sticky expiry flag and IRQ. It sits beside the core at top level, on the same clock, with DATA shared as a tri-state bus.

## Interface
- RAM_AW, 10, RAM address width; RAM holds 2^RAM_AW words.
- FIFO_DEPTH, 8, TX FIFO depth in words; must be a power of two, at least 2.
- CLK  in  1  system clock; all state updates on the rising edge.
- RES  in  1  reset, asynchronous, active-high.
- RD  in  1  core load strobe; single cycle, combinational from core.
- WR  in  1  core store strobe; single cycle.
- ADDR  in  16  word address.
- DATA  inout  16  driven by this block only while RD=1 and WR=0, else high-Z.
- OUT_VALID  out  1  FIFO head valid.
- OUT_DATA  out  16  FIFO head word.
- OUT_READY  in  1  sink accepts head.
- IRQ  out  1  equals STATUS.TEXP.

## Operation
- Decode rules:
  - ADDR[15]=0 selects RAM, indexed by ADDR[RAM_AW-1:0]; higher bits alias.
  - ADDR[15]=1 selects I/O, decoded on ADDR[3:0]; ADDR[14:4] are ignored.
- I/O map:
  - 0x0 TXDATA: a write pushes the word into the FIFO. A read returns the zero-extended FIFO level (0..FIFO_DEPTH).
  - 0x1 STATUS: bit0 EMPTY, bit1 FULL, bit2 OVF (sticky), bit3 TEXP (sticky); other bits read 0. A write clears OVF and/or TEXP wherever the corresponding DATA bit is 1; EMPTY and FULL are read-only.
  - 0x2 RELOAD: read/write. A write also loads COUNT with the written value on the same edge.
  - 0x3 COUNT: read-only; writes are ignored.
  - 0x4..0xF: reads return 0; writes are ignored.
- Bus rules:
  - Reads are combinational: DATA reflects RAM or register contents in the same cycle RD=1, with no wait states.
  - Writes commit at the rising edge while WR=1.
  - If RD=1 and WR=1, the cycle is a write and DATA is not driven.
- FIFO:
  - First-word fall-through: OUT_DATA is the head word whenever OUT_VALID=1.
  - A pop occurs when OUT_VALID and OUT_READY are both 1.
  - A push when full with no pop in the same cycle is dropped and sets OVF.
  - A push when full with a pop in the same cycle is accepted; the level is unchanged.
  - A push when empty with OUT_READY=1 does not pass straight through; OUT_VALID rises on the next cycle.
- Timer:
  - RELOAD=0 stops the timer; COUNT holds its value.
  - Otherwise COUNT decrements by 1 each cycle.
  - When COUNT=1, the next value is RELOAD and TEXP is set.
  - If COUNT=0 and RELOAD is nonzero (after a clear), COUNT loads RELOAD on the next edge without setting TEXP.
  - All arithmetic is unsigned 16-bit.
- Simultaneous events:
  - A TEXP set and a write-1-to-clear in the same cycle: set wins.
  - An overflow push and an OVF clear in the same cycle: set wins.
  - A RELOAD write overrides the decrement in that cycle.

## Timing
- Reset values:
  - FIFO empty: OUT_VALID=0, level 0.
  - OUT_DATA=0 while empty.
  - OVF=0, TEXP=0, IRQ=0.
  - RELOAD=0, COUNT=0.
  - DATA high-Z.
  - RAM contents are not reset.
- Reset asserted mid-operation:
  - Immediately empties the FIFO and drops OUT_VALID.
  - Any partially accepted push is lost.
- Read latency is 0 cycles, combinational: ADDR to DATA.
- Write latency is 1 edge.
- FIFO latency:
  - A push at edge N gives OUT_VALID=1 after edge N.
  - A pop at edge N exposes the next head after edge N.
- Timer: a RELOAD write of R at edge N gives TEXP=1 after edge N+R, and IRQ rises on the same edge.

## Structure
- Package bus_target_pkg holds:
  - I/O offsets: TXDATA=4'h0, STATUS=4'h1, RELOAD=4'h2, COUNT=4'h3.
  - STATUS bit indices: EMPTY=0, FULL=1, OVF=2, TEXP=3.
  - The I/O select bit index, 15.
- One sub-module, sync_fifo, parameterized by width and depth:
  - Ports: push/pop handshake, level, full, empty.
  - Pointers carry one extra wrap bit to distinguish full from empty.
- The RAM, decode, STATUS, and timer logic live in bus_target itself.

## Test plan
- Reset, then write 0x1234 to 0x0005 and read 0x0005 → DATA=0x1234 in the RD cycle; read 0x0405 with RAM_AW=10 → 0x1234 via aliasing.
- Push 8 words 0x00A0..0x00A7 with OUT_READY=0, then push 0x00FF → level read at 0x8000 is 8; STATUS=0x0006 (FULL, OVF); 0x00FF is dropped. Then hold OUT_READY=1 → OUT_DATA is 0x00A0..0x00A7 on consecutive cycles and STATUS ends 0x0005.
- With the FIFO full, push 0x0055 in the same cycle as a pop → no OVF, level stays 8, and 0x0055 emerges last.
- Write RELOAD=3 at edge N → COUNT reads 3, 2, 1, then 3 again; TEXP and IRQ rise after edge N+3. Write 0x0008 to STATUS → IRQ=0; a clear coinciding with an expiry leaves IRQ=1.
- Assert RES while the FIFO holds 4 words and COUNT=0x0100 → OUT_VALID=0 and COUNT=0 asynchronously; after release, a read of 0x8000 returns 0.
- Drive RD=WR=1 at 0x8002 with 0x0007 → DATA is not driven by the block, and RELOAD=7 after the edge.
